pipe_stage_buf: RTL

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : two-entry valid/ready pipeline stage (main + skid register)
// Optional statistics counters enabled by macro PIPE_STAGE_STATS_EN
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_fire;
  logic              dn_fire;

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_buf: DATA_W and CNT_W must be at least 1");
  end

  // Handshake outputs come from state only, so up_ready never sees dn_ready.
  assign dn_valid = (state_q != EMPTY);
  assign up_ready = (state_q != FULL);
  assign dn_data  = main_q;

  assign up_fire  = up_valid & up_ready;
  assign dn_fire  = dn_valid & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_fire) begin
            state_d = ONE;
            main_d  = up_data;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            main_d = up_data;
          end else if (up_fire) begin
            state_d = FULL;
            skid_d  = up_data;
          end else if (dn_fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          if (dn_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Counters saturate at all-ones; flush deliberately leaves them alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (dn_valid && !dn_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!dn_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
`endif

endmodule

`default_nettype wire
